// File: rtl/cpu_mem_pkg.sv
// Types and constants shared by the CPU data-memory path:
// the responder FSM states, the full-word byte enable and the word-alignment mask.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0]  BE_WORD         = 4'hF;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return (byte_addr & WORD_ALIGN_MASK) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array, one byte-wide memory per lane so each lane maps to its
// own block RAM with a byte write enable. Read data is registered.
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rdata_reg;

            always_ff @(posedge clock) begin
                if (en) begin
                    if (we && be[gi]) begin
                        lane_mem[addr] <= wdata[8*gi +: 8];
                    end
                    if (!we) begin
                        lane_rdata_reg <= lane_mem[addr];
                    end
                end
            end

            assign rdata[8*gi +: 8] = lane_rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: accepts one request, waits
// WAIT_CYCLES, performs the array access and holds the response until taken.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;
    logic        rd_ok_reg;

    logic        addr_err;
    logic        access_now;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_rdata;

    assign addr_err   = is_misaligned(addr_reg) || ((addr_reg >> (ADDR_W + 2)) != 32'd0);
    assign access_now = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
    // Errored requests never touch the array, so a bad write cannot corrupt it.
    assign mem_en     = access_now && !addr_err;
    assign mem_we     = mem_en && we_reg;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (addr_reg[ADDR_W+1:2]),
        .wdata (wdata_reg),
        .be    (be_reg & BE_WORD),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            be_reg        <= 4'd0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rd_ok_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        be_reg    <= req_be;
                        cnt_reg   <= WAIT_INIT;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= addr_err;
                        rd_ok_reg     <= !we_reg && !addr_err;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        rd_ok_reg     <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    // The array read register only changes on a successful read access, so it is stable through RESP.
    assign rsp_rdata = (rsp_valid_reg && rd_ok_reg) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stimulus pushes expected responses into a
// queue, a monitor pops and compares at every response handshake.
module tb_dmem_responder;
    import cpu_mem_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    dmem_responder #(
        .ADDR_W      (8),
        .WAIT_CYCLES (2)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one line per completed response.
    always @(negedge clock) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("rsp %s: rdata 0x%08h err %0b (want 0x%08h err %0b)",
                         e.name, rsp_rdata, rsp_err, e.rdata, e.err);
                check({e.name, "_rdata"}, rsp_rdata, e.rdata);
                check({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Issues a request and waits for its accept edge (all driving is at posedge+1).
    task automatic issue(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!req_ready && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!req_ready) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clock);
        #1;
        // Scramble the request lines: the DUT must have captured them at the accept edge.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err, input int bp);
        exp_t e;
        int lat;
        logic [31:0] held_rdata;
        logic held_err;
        e.name = name;
        e.rdata = exp_rdata;
        e.err = exp_err;
        issue(name, we, addr, wdata, be);
        exp_q.push_back(e);
        if (bp == 0) rsp_ready = 1'b1;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd3);
        if (bp > 0) begin
            held_rdata = rsp_rdata;
            held_err   = rsp_err;
            for (int i = 0; i < bp; i++) begin
                @(posedge clock);
                #1;
                check({name, "_bp_valid"}, {31'd0, rsp_valid}, 32'd1);
                check({name, "_bp_rdata"}, rsp_rdata, held_rdata);
                check({name, "_bp_err"}, {31'd0, rsp_err}, {31'd0, held_err});
                check({name, "_bp_req_ready"}, {31'd0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        check({name, "_post_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({name, "_post_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #12;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        txn("wr_full",      1'b1, 32'h10,  32'hDEADBEEF, BE_WORD, 32'h0,        1'b0, 0);
        txn("rd_full",      1'b0, 32'h10,  32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 0);
        txn("wr_partial",   1'b1, 32'h10,  32'h11223344, 4'b0101, 32'h0,        1'b0, 0);
        txn("rd_partial",   1'b0, 32'h10,  32'h0,        4'h0,    32'hDE22BE44, 1'b0, 0);
        txn("rd_misalign",  1'b0, 32'h13,  32'h0,        4'h0,    32'h0,        1'b1, 0);
        txn("rd_after_mis", 1'b0, 32'h10,  32'h0,        4'h0,    32'hDE22BE44, 1'b0, 0);
        txn("wr_zero",      1'b1, 32'h0,   32'h12345678, BE_WORD, 32'h0,        1'b0, 0);
        txn("wr_range",     1'b1, 32'h400, 32'hAAAAAAAA, BE_WORD, 32'h0,        1'b1, 0);
        txn("rd_zero",      1'b0, 32'h0,   32'h0,        4'h0,    32'h12345678, 1'b0, 0);
        txn("wr_20",        1'b1, 32'h20,  32'h0BADF00D, BE_WORD, 32'h0,        1'b0, 0);
        txn("rd_20_bp",     1'b0, 32'h20,  32'h0,        4'h0,    32'h0BADF00D, 1'b0, 5);
        txn("wr_be0",       1'b1, 32'h20,  32'hFFFFFFFF, 4'h0,    32'h0,        1'b0, 0);
        txn("rd_after_be0", 1'b0, 32'h20,  32'h0,        4'h0,    32'h0BADF00D, 1'b0, 0);

        // Abort a write during its wait states.
        issue("wr_abort", 1'b1, 32'h20, 32'hCAFEF00D, BE_WORD);
        @(posedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'd0);
        check("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
        $display("reset asserted during wr_abort wait");
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        txn("rd_after_abort", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0);

        repeat (2) @(posedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the CPU's load/store port. It accepts one word-aligned read or write request per transaction over a valid/ready handshake, inserts a configurable number of wait states, performs the access on an internal word array, and returns read data or a write acknowledge with an error flag. It is the memory side of the CPU data interface: the CPU issues `lw`/`sw`, and this block answers them.

## Interface
- `ADDR_W`, default 8: word-address width; array depth = 2**ADDR_W words.
- `WAIT_CYCLES`, default 2: wait states inserted between accept and access, range 0..15.
- `clock`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_we`  in  1  1 = write (`sw`), 0 = read (`lw`).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `req_be`  in  4  byte enables for writes; bit i covers bits 8i+7:8i.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester accepts response.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  1 = misaligned or out-of-range address.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch we/addr/wdata/be, load wait counter with `WAIT_CYCLES`, go to WAIT.
- WAIT: if counter != 0, decrement. If counter == 0, perform the access, drive the response registers, set `rsp_valid`, go to RESP.
- RESP: hold `rsp_valid`, `rsp_rdata`, `rsp_err` stable until `rsp_valid && rsp_ready`, then clear `rsp_valid` and return to IDLE.
- Error check at access: `addr[1:0] != 0` or `addr[31:ADDR_W+2] != 0` -> `rsp_err`=1, `rsp_rdata`=0, no array write.
- Read: `rsp_rdata` = `mem[addr[ADDR_W+1:2]]`.
- Write: each byte with `be[i]`=1 is updated and the others are kept. `be`=0 is legal: no change, `rsp_err`=0. `rsp_rdata`=0.
- Array contents are not reset and are undefined until written.
- Request inputs are sampled only at the accept edge; later changes are ignored.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, counter 0.
- Accept edge k -> array write or read at edge k+1+WAIT_CYCLES. `rsp_valid` is high in the cycle after that edge.
- Response handshake at edge m -> `req_ready` is high in cycle m+1. No request is accepted in the same cycle as a response handshake.
- Minimum transaction spacing: WAIT_CYCLES+3 cycles when `rsp_ready` is held high.
- `req_ready` is low in WAIT and RESP. `req_valid` asserted there is held off; the requester keeps it asserted.
- Reset asserted mid-transaction aborts it immediately:
  - If the abort precedes the access edge, no array write occurs.
  - A write already committed stays committed.
  - Outputs return to their reset values asynchronously.
- `rsp_ready` high while `rsp_valid` is low has no effect.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_WAIT`, `ST_RESP`);
  - the byte-enable constant `BE_WORD`=4'hF;
  - the word-alignment mask constant.
- Sub-module `dmem_array`: single-port word array with per-byte write enables and registered read data. It is instantiated once. The FSM, error check and handshake stay in `dmem_responder`.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x10 with be=4'hF, then read 0x10 -> rdata 0xDEADBEEF, err 0. With WAIT_CYCLES=2, `rsp_valid` rises 3 edges after each accept.
- Partial write: be=4'b0101, wdata 0x11223344 to addr 0x10 holding 0xDEADBEEF, then read -> 0xDE22BE44.
- Misaligned read at addr 0x13 -> err 1, rdata 0; array unchanged (read 0x10 still 0xDE22BE44).
- Out-of-range write at addr 0x400 (ADDR_W=8) -> err 1; then read 0x000 -> unchanged.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` -> outputs stable and `req_ready`=0 throughout; after the handshake, `req_ready`=1 in the next cycle.
- Reset mid-operation: assert `rst_n`=0 during WAIT of a write of 0xCAFEF00D to 0x20 -> outputs at reset values at once; a later read of 0x20 returns its prior value.
